// File: rtl/eq_exerciser_pkg.sv
// Shared types and sizing helpers for the equality-comparator exerciser.
package eq_exerciser_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CHECK,
    FINISH
  } state_e;

  function automatic int num_vec(input int n);
    return 1 << (2 * n);
  endfunction

  function automatic int cnt_w(input int s);
    return (s > 1) ? $clog2(s) : 1;
  endfunction

endpackage

// File: rtl/eq_exerciser.sv
// Exhaustive on-chip sweep of an N-bit equality comparator with a golden
// model, error count and first-failing-vector capture.
module eq_exerciser
  import eq_exerciser_pkg::*;
#(
  parameter int N_BITS        = 2,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic [N_BITS-1:0]   a_o,
  output logic [N_BITS-1:0]   b_o,
  input  logic                dut_eq,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [2*N_BITS:0]   err_cnt,
  output logic                fail_valid,
  output logic [2*N_BITS-1:0] fail_vec
);

  localparam int VW = 2 * N_BITS;
  localparam int NV = num_vec(N_BITS);
  localparam int CW = cnt_w(SETTLE_CYCLES);
  localparam logic [CW-1:0] SLOAD = CW'(SETTLE_CYCLES - 1);
  localparam logic [VW-1:0] LAST  = VW'(NV - 1);

  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("SETTLE_CYCLES must be at least 1");
  end

  state_e        state_q, state_d;
  logic [VW-1:0] idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [VW:0]   err_q, err_d;
  logic          fv_q, fv_d;
  logic [VW-1:0] fvec_q, fvec_d;
  logic          pass_q, pass_d;
  logic          mis;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      fv_q    <= 1'b0;
      fvec_q  <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      fvec_q  <= fvec_d;
      pass_q  <= pass_d;
    end
  end

  // Golden model: the operands are still held while dut_eq is sampled.
  assign mis = dut_eq != (a_o == b_o);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    fv_d    = fv_q;
    fvec_d  = fvec_q;
    pass_d  = pass_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          idx_d   = '0;
          err_d   = '0;
          fv_d    = 1'b0;
          fvec_d  = '0;
          pass_d  = 1'b0;
          cnt_d   = SLOAD;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          state_d = CHECK;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      CHECK: begin
        if (mis) begin
          err_d = err_q + (VW+1)'(1);
          if (!fv_q) begin
            fv_d   = 1'b1;
            fvec_d = idx_q;
          end
        end
        if (idx_q == LAST) begin
          pass_d  = (err_d == '0);
          state_d = FINISH;
        end else begin
          idx_d   = idx_q + VW'(1);
          cnt_d   = SLOAD;
          state_d = SETTLE;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign a_o        = idx_q[VW-1:N_BITS];
  assign b_o        = idx_q[N_BITS-1:0];
  assign busy       = (state_q == SETTLE) || (state_q == CHECK);
  assign done       = (state_q == FINISH);
  assign pass       = pass_q;
  assign err_cnt    = err_q;
  assign fail_valid = fv_q;
  assign fail_vec   = fvec_q;

endmodule

// File: tb/tb_eq_exerciser.sv
// Directed bench: fault-injected comparators, delayed comparators,
// mid-sweep reset and ignored start pulses.
module tb_eq_exerciser;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start [3];
  logic [1:0] a [3];
  logic [1:0] b [3];
  logic       eq [3];
  logic       busy [3];
  logic       done [3];
  logic       pass [3];
  logic [4:0] ec [3];
  logic       fv [3];
  logic [3:0] fvec [3];

  int mode = 0;
  int checks = 0;
  int errors = 0;
  logic d1a, d1b, d2a, d2b;

  always #5 clk = ~clk;

  // Instance 0: comparator with selectable fault
  always_comb begin
    case (mode)
      1: eq[0] = 1'b0;
      2: eq[0] = 1'b1;
      3: eq[0] = (a[0] != b[0]);
      default: eq[0] = (a[0] == b[0]);
    endcase
  end

  // Instances 1 and 2: comparator output through a 2-stage register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      d1a <= 1'b0; d1b <= 1'b0;
      d2a <= 1'b0; d2b <= 1'b0;
    end else begin
      d1a <= (a[1] == b[1]); d1b <= d1a;
      d2a <= (a[2] == b[2]); d2b <= d2a;
    end
  end
  assign eq[1] = d1b;
  assign eq[2] = d2b;

  eq_exerciser #(.N_BITS(2), .SETTLE_CYCLES(1)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]),
    .a_o(a[0]), .b_o(b[0]), .dut_eq(eq[0]),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]),
    .err_cnt(ec[0]), .fail_valid(fv[0]), .fail_vec(fvec[0])
  );

  eq_exerciser #(.N_BITS(2), .SETTLE_CYCLES(3)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]),
    .a_o(a[1]), .b_o(b[1]), .dut_eq(eq[1]),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]),
    .err_cnt(ec[1]), .fail_valid(fv[1]), .fail_vec(fvec[1])
  );

  eq_exerciser #(.N_BITS(2), .SETTLE_CYCLES(1)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start[2]),
    .a_o(a[2]), .b_o(b[2]), .dut_eq(eq[2]),
    .busy(busy[2]), .done(done[2]), .pass(pass[2]),
    .err_cnt(ec[2]), .fail_valid(fv[2]), .fail_vec(fvec[2])
  );

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Runs one sweep on instance s; optionally pulses start again mid-sweep.
  task automatic run(input int s, input bit extra,
                     output int nbusy, output int dat, output bit clr);
    nbusy = 0;
    dat = -1;
    clr = 1'b0;
    @(negedge clk);
    start[s] = 1'b1;
    @(posedge clk);
    #1;
    start[s] = 1'b0;
    clr = (ec[s] == 5'd0) && !fv[s] && (fvec[s] == 4'd0) && !pass[s];
    for (int k = 0; k < 300; k++) begin
      if (busy[s]) nbusy++;
      if (done[s]) begin
        dat = k;
        break;
      end
      start[s] = extra && (k == 10);
      @(posedge clk);
      #1;
    end
    start[s] = 1'b0;
  endtask

  typedef struct {
    int   mode;
    bit   extra;
    int   err;
    bit   fv;
    int   fvec;
    bit   pass;
  } vec_t;

  vec_t tbl [5];

  initial begin
    int nb, dat, n, seen;
    bit clr;
    logic [4:0] hold;

    tbl[0] = '{0, 1'b0, 0,  1'b0, 0, 1'b1};
    tbl[1] = '{1, 1'b1, 4,  1'b1, 0, 1'b0};
    tbl[2] = '{2, 1'b0, 12, 1'b1, 1, 1'b0};
    tbl[3] = '{3, 1'b0, 16, 1'b1, 0, 1'b0};
    tbl[4] = '{0, 1'b0, 0,  1'b0, 0, 1'b1};

    for (int i = 0; i < 3; i++) start[i] = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy[0]), 0);
    chk("rst_done", int'(done[0]), 0);
    chk("rst_pass", int'(pass[0]), 0);
    chk("rst_err", int'(ec[0]), 0);
    chk("rst_fv", int'(fv[0]), 0);
    chk("rst_ab", int'({a[0], b[0], fvec[0]}), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      mode = tbl[i].mode;
      run(0, tbl[i].extra, nb, dat, clr);
      chk($sformatf("v%0d_clear", i), int'(clr), 1);
      chk($sformatf("v%0d_busy", i), nb, 32);
      chk($sformatf("v%0d_done_at", i), dat, 32);
      chk($sformatf("v%0d_err", i), int'(ec[0]), tbl[i].err);
      chk($sformatf("v%0d_fv", i), int'(fv[0]), int'(tbl[i].fv));
      chk($sformatf("v%0d_fvec", i), int'(fvec[0]), tbl[i].fvec);
      chk($sformatf("v%0d_pass", i), int'(pass[0]), int'(tbl[i].pass));
      hold = ec[0];
      repeat (3) @(posedge clk);
      #1;
      chk($sformatf("v%0d_hold_err", i), int'(ec[0]), int'(hold));
      chk($sformatf("v%0d_hold_pass", i), int'(pass[0]), int'(tbl[i].pass));
      chk($sformatf("v%0d_hold_ab", i), int'({a[0], b[0]}), 15);
    end

    // Delayed comparator with enough settle time
    run(1, 1'b0, nb, dat, clr);
    chk("s3_busy", nb, 64);
    chk("s3_done_at", dat, 64);
    chk("s3_err", int'(ec[1]), 0);
    chk("s3_pass", int'(pass[1]), 1);

    // Delayed comparator with too little settle time
    run(2, 1'b0, nb, dat, clr);
    chk("s1dly_done_at", dat, 32);
    chk("s1dly_err_nz", int'(ec[2] != 5'd0), 1);
    chk("s1dly_pass", int'(pass[2]), 0);

    // Reset while vector 7 is applied
    mode = 1;
    @(negedge clk);
    start[0] = 1'b1;
    @(posedge clk);
    #1;
    start[0] = 1'b0;
    n = 0;
    while ({a[0], b[0]} != 4'd7 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("mid_reach7", int'(n < 100), 1);
    chk("mid_err_pre", int'(ec[0]), 2);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_outs",
        int'({busy[0], done[0], pass[0], fv[0], ec[0], fvec[0], a[0], b[0]}),
        0);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (done[0] || busy[0]) seen++;
    end
    chk("mid_no_done", seen, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
